spi_master_core: RTL and testbench
==================================

Name: spi_master_core

Overview:
- SPI master engine directly downstream of the SPI control stage. Consumes its enable pulse, tx_data word, addr (chip-select index) and clk_div, and returns busy.
- Shifts one DATA_W-bit frame MSB-first on sclk/mosi, samples miso, and drives one active-low chip select per MEMS device.
- Captured read data is presented with a one-cycle valid strobe.

Parameters:
- DATA_W, 16, frame length in bits; also the width of tx_data and rx_data.
- NUM_CS, 4, number of chip-select lines. Legal addr values are 0..NUM_CS-1.

Ports:
- clk_150MHz_i  input  1  system clock, 150 MHz.
- reset_n  input  1  reset, asynchronous, active-low.
- enable  input  1  start request, one-cycle pulse.
- clk_div  input  32  sclk half-period in clk cycles; 0 is treated as 1.
- addr  input  32  chip-select index.
- tx_data  input  DATA_W  frame to transmit.
- miso  input  1  serial data from slave; synchronous to the SPI timing it produces.
- busy  output  1  transaction in progress.
- sclk  output  1  SPI clock.
- mosi  output  1  serial data to slave.
- cs_n  output  NUM_CS  chip selects, active-low.
- rx_data  output  DATA_W  last received frame.
- rx_valid  output  1  one-cycle strobe: rx_data updated.
- addr_err  output  1  one-cycle strobe: request rejected because addr >= NUM_CS.

Behaviour:
- Reset values (async, immediate while reset_n=0): busy=0, sclk=CPOL, mosi=0, cs_n=all 1, rx_data=0, rx_valid=0, addr_err=0, FSM=IDLE. Reset mid-frame aborts immediately; no rx_valid is issued.
- H = max(clk_div,1), latched at start. Changes to clk_div, addr or tx_data during a frame are ignored.
- Divider counter is 32 bits and counts H cycles per half-period. No overflow for any clk_div value.
- FSM states: IDLE, SETUP, SHIFT, HOLD, DONE, GAP.
- IDLE: enable=1 sampled at edge N.
  - If addr < NUM_CS: latch inputs, and at N+1 busy=1 and state=SETUP.
  - Else: addr_err=1 for cycle N+1, busy stays 0, no SPI activity.
- enable while busy=1 is ignored, with no queueing.
- SETUP (H cycles): cs_n[addr]=0, mosi=tx[DATA_W-1], sclk=CPOL.
- SHIFT (2*DATA_W half-periods, mode 0):
  - Leading edge (rising) each bit: sample miso into shift register LSB.
  - Trailing edge (falling): mosi takes the next bit.
  - After the last trailing edge, go to HOLD. Exactly DATA_W sclk pulses per frame.
- HOLD (H cycles): cs_n still low, sclk=CPOL.
- DONE (1 cycle): cs_n all 1, rx_data=captured frame, rx_valid=1.
- GAP (H cycles): cs_n high, busy=1. Then IDLE with busy=0.
- Busy high for exactly (2*DATA_W+3)*H+1 cycles. DATA_W=16, H=1 gives 36 cycles.
- Earliest next start is an enable sampled in the first cycle busy=0 (back-to-back frames).
- Exactly one cs_n bit is low at any time, and only during SETUP..HOLD.
- mosi returns to 0 in DONE and IDLE.

Optional Feature:
- Macro SPI_MODE3_EN.
- Defined: SPI mode 3.
  - CPOL=1: sclk idles high, including at reset.
  - CPHA=1: mosi changes on the falling (leading) edge; miso is sampled on the rising (trailing) edge.
  - In SETUP, mosi holds tx[DATA_W-1]; each leading edge presents the current bit.
- Undefined: mode 0 as described above (CPOL=0, CPHA=0).
- Frame timing, busy length and edge count are identical in both modes.

Test Plan:
- Mode 0, clk_div=1, addr=0, tx_data=0xA500, miso looped to mosi -> cs_n=4'b1110 during frame; 16 rising edges; rx_data=0xA500 with a single rx_valid pulse; busy high 36 cycles.
- clk_div=0 versus clk_div=1 with tx_data=0x1234 -> identical waveforms. clk_div=3 -> sclk period 6 cycles; busy high 106 cycles.
- addr=5 (NUM_CS=4) with an enable pulse -> addr_err=1 for one cycle; cs_n stays 4'b1111; busy stays 0; sclk idle.
- enable pulses mid-frame, plus tx_data/clk_div changed mid-frame -> ignored; the frame completes with the original values. An enable in the first cycle busy=0 starts the next frame.
- reset_n pulled low after the 7th sclk rising edge -> same cycle: cs_n=4'b1111, sclk=CPOL, busy=0; no rx_valid. After release, a new frame with tx_data=0x00FF completes correctly.
- SPI_MODE3_EN defined, tx_data=0xC3C3 looped back -> sclk idles 1; mosi changes on falling edges; rx_data=0xC3C3; busy length as in mode 0.

Source files
------------

// File: rtl/spi_master_core.sv
// SPI master engine: one DATA_W-bit MSB-first frame per accepted enable, one active-low chip select per device.
// Default build is SPI mode 0; defining SPI_MODE3_EN selects mode 3 (CPOL=1, CPHA=1) with identical frame timing.
module spi_master_core #(
  parameter int DATA_W = 16,
  parameter int NUM_CS = 4
) (
  input  logic              clk_150MHz_i,
  input  logic              reset_n,
  input  logic              enable,
  input  logic [31:0]       clk_div,
  input  logic [31:0]       addr,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              miso,
  output logic              busy,
  output logic              sclk,
  output logic              mosi,
  output logic [NUM_CS-1:0] cs_n,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              addr_err
);

`ifdef SPI_MODE3_EN
  localparam logic CPOL = 1'b1;
  localparam logic CPHA = 1'b1;
`else
  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;
`endif

  localparam int CS_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int HC_W = $clog2(2 * DATA_W);
  localparam logic [HC_W-1:0] LAST_HALF = HC_W'(2 * DATA_W - 1);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] SHIFT = 3'd2;
  localparam logic [2:0] HOLD  = 3'd3;
  localparam logic [2:0] DONE  = 3'd4;
  localparam logic [2:0] GAP   = 3'd5;

  logic [2:0]        state;
  logic [31:0]       half_len;
  logic [31:0]       cnt;
  logic [HC_W-1:0]   half_cnt;
  logic [HC_W-1:0]   next_half;
  logic [CS_W-1:0]   cs_idx;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              half_end;
  logic              enter_half;
  logic              sample_now;
  logic              shift_now;

  // Each sclk half-period starts on a clk edge; even halves begin with the leading edge, odd halves with the trailing edge.
  always_comb begin
    half_end   = (cnt == half_len - 32'd1);
    enter_half = 1'b0;
    next_half  = '0;
    if (state == SETUP && half_end) begin
      enter_half = 1'b1;
    end else if (state == SHIFT && half_end && half_cnt != LAST_HALF) begin
      enter_half = 1'b1;
      next_half  = half_cnt + HC_W'(1);
    end
    sample_now = enter_half && (next_half[0] == CPHA);
    shift_now  = enter_half && (next_half[0] != CPHA) && (next_half != '0);
  end

  assign busy = (state != IDLE);
  assign cs_n = (state == SETUP || state == SHIFT || state == HOLD) ?
                ~(NUM_CS'(1) << cs_idx) : {NUM_CS{1'b1}};

  always_ff @(posedge clk_150MHz_i or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      half_len <= 32'd1;
      cnt      <= '0;
      half_cnt <= '0;
      cs_idx   <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk     <= CPOL;
      mosi     <= 1'b0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      addr_err <= 1'b0;
      if (enter_half) begin
        sclk     <= CPOL ^ ~next_half[0];
        half_cnt <= next_half;
      end
      if (sample_now) begin
        rx_sr <= {rx_sr[DATA_W-2:0], miso};
      end
      if (shift_now) begin
        tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        mosi  <= tx_sr[DATA_W-2];
      end
      case (state)
        IDLE: begin
          if (enable) begin
            if (addr < 32'(NUM_CS)) begin
              state    <= SETUP;
              half_len <= (clk_div == 32'd0) ? 32'd1 : clk_div;
              cnt      <= '0;
              cs_idx   <= addr[CS_W-1:0];
              tx_sr    <= tx_data;
              rx_sr    <= '0;
              mosi     <= tx_data[DATA_W-1];
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        SETUP: begin
          if (half_end) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        SHIFT: begin
          if (half_end) begin
            cnt <= '0;
            if (half_cnt == LAST_HALF) begin
              state <= HOLD;
            end
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        HOLD: begin
          // Publishing on this edge makes rx_valid coincide with the single DONE cycle.
          if (half_end) begin
            cnt      <= '0;
            state    <= DONE;
            rx_data  <= rx_sr;
            rx_valid <= 1'b1;
            mosi     <= 1'b0;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        DONE: begin
          state <= GAP;
        end
        GAP: begin
          if (half_end) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: a per-cycle timeline model of each frame, miso looped back to mosi,
// and directed frames with hand-computed expectations. Follows SPI_MODE3_EN like the design.
module tb_spi_master_core;

  localparam int D = 16;
`ifdef SPI_MODE3_EN
  localparam bit MODE3 = 1'b1;
`else
  localparam bit MODE3 = 1'b0;
`endif
  localparam logic IDLE_SCLK = MODE3;

  logic        clk;
  logic        reset_n;
  logic        enable;
  logic [31:0] clk_div;
  logic [31:0] addr;
  logic [15:0] tx_data;
  logic        miso;
  logic        busy;
  logic        sclk;
  logic        mosi;
  logic [3:0]  cs_n;
  logic [15:0] rx_data;
  logic        rx_valid;
  logic        addr_err;

  int checks = 0;
  int passes = 0;
  bit chk_on = 1'b0;

  int busy_total = 0;
  int rv_total   = 0;
  int err_total  = 0;
  int rise_total = 0;

  // Frame model: a frame is a start time plus latched H, tx and addr; outputs follow from cycle offset arithmetic.
  bit          m_active = 1'b0;
  int          m_k      = 0;
  int          m_h      = 1;
  int          m_addr   = 0;
  logic [15:0] m_tx     = '0;
  logic [15:0] exp_rx   = '0;
  logic        exp_err  = 1'b0;

  logic [7:0]  ev;
  logic [15:0] ev_rx;
  logic        ev_err;

  spi_master_core #(.DATA_W(16), .NUM_CS(4)) dut (
    .clk_150MHz_i(clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .clk_div     (clk_div),
    .addr        (addr),
    .tx_data     (tx_data),
    .miso        (miso),
    .busy        (busy),
    .sclk        (sclk),
    .mosi        (mosi),
    .cs_n        (cs_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .addr_err    (addr_err)
  );

  assign miso = mosi;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Returns {busy, sclk, mosi, rx_valid, cs_n[3:0]} for cycle k (1 = first busy cycle) of a frame.
  function automatic logic [7:0] expectOutputs(input bit act, input int k, input int h,
                                                input logic [15:0] tx, input int a);
    logic       e_sclk;
    logic       e_mosi;
    logic       e_rv;
    logic [3:0] e_cs;
    int         j;
    int         hh;
    int         idx;
    e_sclk = IDLE_SCLK;
    e_mosi = 1'b0;
    e_rv   = 1'b0;
    e_cs   = 4'hF;
    if (act) begin
      j = k - 1;
      if (j < h) begin
        e_cs   = ~(4'b0001 << a);
        e_mosi = tx[15];
      end else if (j < h + 2 * D * h) begin
        hh     = (j - h) / h;
        e_cs   = ~(4'b0001 << a);
        e_sclk = MODE3 ? (hh % 2 == 1) : (hh % 2 == 0);
        idx    = MODE3 ? 15 - hh / 2 : 15 - (hh + 1) / 2;
        e_mosi = (idx >= 0) ? tx[idx] : 1'b0;
      end else if (j < 2 * h + 2 * D * h) begin
        e_cs   = ~(4'b0001 << a);
        e_mosi = MODE3 ? tx[0] : 1'b0;
      end else if (j == 2 * h + 2 * D * h) begin
        e_rv = 1'b1;
      end
    end
    return {act, e_sclk, e_mosi, e_rv, e_cs};
  endfunction

  always @(posedge clk) begin
    if (!reset_n) begin
      m_active <= 1'b0;
      m_k      <= 0;
      exp_rx   <= '0;
      exp_err  <= 1'b0;
    end else begin
      exp_err <= 1'b0;
      if (m_active) begin
        if (m_k + 1 > (2 * D + 3) * m_h + 1) m_active <= 1'b0;
        else if (m_k == 2 * m_h + 2 * D * m_h) exp_rx <= m_tx;
        m_k <= m_k + 1;
      end else if (enable) begin
        if (addr < 32'd4) begin
          m_active <= 1'b1;
          m_k      <= 1;
          m_h      <= (clk_div == 32'd0) ? 1 : int'(clk_div);
          m_tx     <= tx_data;
          m_addr   <= int'(addr);
        end else begin
          exp_err <= 1'b1;
        end
      end
    end
  end

  assign ev     = reset_n ? expectOutputs(m_active, m_k, m_h, m_tx, m_addr) : {1'b0, IDLE_SCLK, 6'b001111};
  assign ev_rx  = reset_n ? exp_rx : 16'h0000;
  assign ev_err = reset_n ? exp_err : 1'b0;

  always @(negedge clk) begin
    if (chk_on) begin
      checkOutput("busy", 32'(busy), 32'(ev[7]));
      checkOutput("sclk", 32'(sclk), 32'(ev[6]));
      checkOutput("mosi", 32'(mosi), 32'(ev[5]));
      checkOutput("rx_valid", 32'(rx_valid), 32'(ev[4]));
      checkOutput("cs_n", 32'(cs_n), 32'(ev[3:0]));
      checkOutput("rx_data", 32'(rx_data), 32'(ev_rx));
      checkOutput("addr_err", 32'(addr_err), 32'(ev_err));
    end
  end

  always @(negedge clk) begin
    if (busy) busy_total <= busy_total + 1;
    if (rx_valid) rv_total <= rv_total + 1;
    if (addr_err) err_total <= err_total + 1;
  end

  always @(posedge sclk) begin
    if (reset_n) rise_total <= rise_total + 1;
  end

  // Called just after a rising clk edge; returns in the first idle cycle so the next call starts back-to-back.
  task automatic applyStimulus(input logic [15:0] tx, input logic [31:0] a, input logic [31:0] div,
                               input bit disturb, input logic [3:0] cs_exp, input int busy_exp,
                               input logic [15:0] rx_exp);
    int b0;
    int v0;
    int e0;
    int r0;
    b0 = busy_total;
    v0 = rv_total;
    e0 = err_total;
    r0 = rise_total;
    tx_data = tx;
    addr    = a;
    clk_div = div;
    enable  = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    if (a >= 32'd4) begin
      repeat (3) begin @(posedge clk); #1; end
      checkOutput("rej_err_pulses", 32'(err_total - e0), 32'd1);
      checkOutput("rej_busy_cycles", 32'(busy_total - b0), 32'd0);
      checkOutput("rej_cs_n", 32'(cs_n), 32'(cs_exp));
      checkOutput("rej_sclk_rises", 32'(rise_total - r0), 32'd0);
      checkOutput("rej_rx_data", 32'(rx_data), 32'(rx_exp));
      return;
    end
    checkOutput("start_busy", 32'(busy), 32'd1);
    checkOutput("start_cs_n", 32'(cs_n), 32'(cs_exp));
    if (disturb) begin
      repeat (5) begin @(posedge clk); #1; end
      tx_data = ~tx;
      clk_div = 32'd7;
      addr    = 32'd1;
      enable  = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      repeat (8) begin @(posedge clk); #1; end
      addr   = 32'd9;
      enable = 1'b1;
      @(posedge clk); #1;
      enable = 1'b0;
      checkOutput("mid_cs_n", 32'(cs_n), 32'(cs_exp));
    end
    for (int n = 0; n < 2000 && busy; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("frame_end", 32'(busy), 32'd0);
    checkOutput("busy_cycles", 32'(busy_total - b0), 32'(busy_exp));
    checkOutput("rx_frame", 32'(rx_data), 32'(rx_exp));
    checkOutput("rx_pulses", 32'(rv_total - v0), 32'd1);
    checkOutput("sclk_rises", 32'(rise_total - r0), 32'd16);
    checkOutput("err_pulses", 32'(err_total - e0), 32'd0);
    checkOutput("idle_cs_n", 32'(cs_n), 32'hF);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, %0d/%0d so far", passes, checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int r0;
    int v0;
    reset_n = 1'b1;
    enable  = 1'b0;
    clk_div = 32'd1;
    addr    = 32'd0;
    tx_data = 16'h0000;
    #2 reset_n = 1'b0;
    #1 chk_on = 1'b1;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_sclk", 32'(sclk), 32'(IDLE_SCLK));
    checkOutput("reset_cs_n", 32'(cs_n), 32'hF);
    checkOutput("reset_rx_data", 32'(rx_data), 32'h0);
    checkOutput("reset_mosi", 32'(mosi), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] basic, divider and address-reject frames");
    applyStimulus(16'hA500, 32'd0, 32'd1, 1'b0, 4'b1110, 36, 16'hA500);
    applyStimulus(16'h1234, 32'd1, 32'd0, 1'b0, 4'b1101, 36, 16'h1234);
    applyStimulus(16'h1234, 32'd1, 32'd1, 1'b0, 4'b1101, 36, 16'h1234);
    applyStimulus(16'h5A3C, 32'd3, 32'd3, 1'b0, 4'b0111, 106, 16'h5A3C);
    applyStimulus(16'hBEEF, 32'd5, 32'd1, 1'b0, 4'b1111, 0, 16'h5A3C);
    repeat (2) begin @(posedge clk); #1; end

    $display("[TB] mid-frame disturbance then back-to-back frame");
    applyStimulus(16'h3C96, 32'd2, 32'd1, 1'b1, 4'b1011, 36, 16'h3C96);
    applyStimulus(16'h8001, 32'd3, 32'd1, 1'b0, 4'b0111, 36, 16'h8001);

    $display("[TB] reset during a frame");
    tx_data = 16'hFFFF;
    addr    = 32'd0;
    clk_div = 32'd2;
    enable  = 1'b1;
    r0 = rise_total;
    v0 = rv_total;
    @(posedge clk); #1;
    enable = 1'b0;
    for (int n = 0; n < 400 && (rise_total - r0) < 7; n++) begin
      @(posedge clk); #1;
    end
    checkOutput("seven_rises", 32'(rise_total - r0), 32'd7);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_cs_n", 32'(cs_n), 32'hF);
    checkOutput("abort_sclk", 32'(sclk), 32'(IDLE_SCLK));
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_mosi", 32'(mosi), 32'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("abort_no_valid", 32'(rv_total - v0), 32'd0);
    checkOutput("abort_rx_data", 32'(rx_data), 32'h0);
    applyStimulus(16'h00FF, 32'd1, 32'd1, 1'b0, 4'b1101, 36, 16'h00FF);

    $display("[TB] alternating pattern frame");
    applyStimulus(16'hC3C3, 32'd0, 32'd1, 1'b0, 4'b1110, 36, 16'hC3C3);
    repeat (3) begin @(posedge clk); #1; end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
